// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, opcodes and sequencer state encodings for the register-file controller
package rf_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADR_W_DEF = 3;
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_LOADI = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_NOP_LO = 4'd12;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;
endpackage

// File: rtl/rf_alu.sv
// rf_alu: combinational datapath producing result, flags and write/flag enables per opcode
module rf_alu import rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z,
  output logic              n,
  output logic              wr_en,
  output logic              c_en
);
  logic [DATA_W:0] sum;
  logic [DATA_W-1:0] b_eff;
  logic cin;
  // one shared adder: SUB/DEC use a + ~b + 1 so carry means "no borrow"
  always_comb begin
    b_eff = op == OP_SUB ? ~b : op == OP_INC ? DATA_W'(1) : op == OP_DEC ? ~DATA_W'(1) : b;
    cin = op == OP_SUB || op == OP_DEC;
    sum = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(cin);
    case (op)
      OP_PASS:  result = a;
      OP_ADD, OP_SUB, OP_INC, OP_DEC: result = sum[DATA_W-1:0];
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL:   result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:   result = {1'b0, a[DATA_W-1:1]};
      OP_LOADI: result = imm;
      default:  result = '0;
    endcase
    c = sum[DATA_W];
    z = result == '0;
    n = result[DATA_W-1];
    wr_en = op < OP_NOP_LO;
    c_en = op == OP_ADD || op == OP_SUB || op == OP_INC || op == OP_DEC;
  end
endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: four-state read/execute/write controller driving an 8x16 register file
module rf_op_sequencer import rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [ADR_W-1:0]  dst_adr,
  input  logic [ADR_W-1:0]  src_r_adr,
  input  logic [ADR_W-1:0]  src_s_adr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] S,
  output logic [ADR_W-1:0]  R_Adr,
  output logic [ADR_W-1:0]  S_Adr,
  output logic [DATA_W-1:0] W,
  output logic [ADR_W-1:0]  W_Adr,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);
  state_t state, next;
  logic [3:0] op_q;
  logic [ADR_W-1:0] dst_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, result;
  logic c, z, n, wr_en, c_en;
  logic pend_c, pend_z, pend_n, pend_c_en, pend_zn_en;
  logic we_d, done_d, busy_d;
  logic [DATA_W-1:0] w_d;
  logic [ADR_W-1:0] w_adr_d;
  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op_q), .a(a_q), .b(b_q), .imm(imm_q),
    .result(result), .c(c), .z(z), .n(n), .wr_en(wr_en), .c_en(c_en)
  );
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : next;
  always_comb
    next = state == S_IDLE ? (start ? S_READ : S_IDLE) :
           state == S_READ ? S_EXEC :
           state == S_EXEC ? S_WRITE : S_IDLE;
  always_comb begin
    we_d = state == S_EXEC && wr_en;
    w_d = we_d ? result : '0;
    w_adr_d = we_d ? dst_q : '0;
    done_d = state == S_EXEC;
    busy_d = next != S_IDLE;
  end
  // flags are held pending through WRITE and committed as that cycle ends
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      a_q <= '0;
      b_q <= '0;
      R_Adr <= '0;
      S_Adr <= '0;
      W <= '0;
      W_Adr <= '0;
      we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      pend_c <= 1'b0;
      pend_z <= 1'b0;
      pend_n <= 1'b0;
      pend_c_en <= 1'b0;
      pend_zn_en <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        op_q <= opcode;
        dst_q <= dst_adr;
        imm_q <= imm;
        R_Adr <= src_r_adr;
        S_Adr <= src_s_adr;
      end
      if (state == S_READ) begin
        a_q <= R;
        b_q <= S;
      end
      if (state == S_EXEC) begin
        pend_c <= c;
        pend_z <= z;
        pend_n <= n;
        pend_c_en <= c_en;
        pend_zn_en <= wr_en;
      end
      if (state == S_WRITE && pend_zn_en) begin
        flag_z <= pend_z;
        flag_n <= pend_n;
      end
      if (state == S_WRITE && pend_c_en)
        flag_c <= pend_c;
      W <= w_d;
      W_Adr <= w_adr_d;
      we <= we_d;
      done <= done_d;
      busy <= busy_d;
    end
  end
endmodule
